// File: rtl/duty_fade_ctrl_pkg.sv
// Shared constants for the RGBW duty fade sequencer.
// State encoding, duty width and channel count.
package duty_fade_ctrl_pkg;

  localparam int DW  = 8;
  localparam int NCH = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FADE = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

endpackage

// File: rtl/duty_fade_ctrl_step.sv
// One channel of the fade ramp: moves cur toward tgt by step,
// clamping at the target so it never overshoots or wraps.
module fade_step
  import duty_fade_ctrl_pkg::*;
(
  input  logic [DW-1:0] cur,
  input  logic [DW-1:0] tgt,
  input  logic [DW-1:0] step,
  output logic [DW-1:0] next,
  output logic          at_target
);

  logic [DW:0] sum;
  logic [DW:0] dif;

  always_comb begin
    sum  = {1'b0, cur} + {1'b0, step};
    dif  = {1'b0, cur} - {1'b0, step};
    next = cur;
    unique case (1'b1)
      cur < tgt: begin
        if (sum >= {1'b0, tgt}) next = tgt;
        else                    next = sum[DW-1:0];
      end
      cur > tgt: begin
        if (dif[DW] || dif[DW-1:0] <= tgt) next = tgt;
        else                               next = dif[DW-1:0];
      end
      default: next = cur;
    endcase
    at_target = (next == tgt);
  end

endmodule

// File: rtl/duty_fade_ctrl.sv
// Ramps four PWM duty registers toward an accepted target colour
// at one step per prescaler tick, or jumps when fading is off.
module duty_fade_ctrl
  import duty_fade_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tgt_valid,
  output logic          tgt_ready,
  input  logic [DW-1:0] tgt0,
  input  logic [DW-1:0] tgt1,
  input  logic [DW-1:0] tgt2,
  input  logic [DW-1:0] tgt3,
  input  logic [DW-1:0] step,
  input  logic          fade_en,
  output logic [DW-1:0] duty0,
  output logic [DW-1:0] duty1,
  output logic [DW-1:0] duty2,
  output logic [DW-1:0] duty3,
  output logic          busy,
  output logic          done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [1:0]               state_q, state_d;
  logic [NCH-1:0][DW-1:0]   duty_q, duty_d;
  logic [NCH-1:0][DW-1:0]   tgt_q, tgt_d;
  logic [DW-1:0]            step_q, step_d;
  logic [PW-1:0]            pre_q, pre_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [NCH-1:0][DW-1:0]   tgt_in;
  logic [NCH-1:0][DW-1:0]   nxt;
  logic [NCH-1:0]           at;
  logic                     tick;

  assign tgt_in = {tgt3, tgt2, tgt1, tgt0};
  assign tick   = (pre_q == PMAX);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    fade_step u_step (
      .cur       (duty_q[c]),
      .tgt       (tgt_q[c]),
      .step      (step_q),
      .next      (nxt[c]),
      .at_target (at[c])
    );
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    pre_d   = pre_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (tgt_valid) begin
          tgt_d  = tgt_in;
          step_d = (step == '0) ? DW'(1) : step;
          pre_d  = '0;
          if (!fade_en || tgt_in == duty_q) begin
            duty_d  = tgt_in;
            state_d = S_FIN;
          end else begin
            state_d = S_FADE;
          end
        end
      end
      state_q == S_FADE: begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (tick) begin
          duty_d = nxt;
          if (&at) state_d = S_FIN;
        end
      end
      state_q == S_FIN: state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= DW'(1);
      pre_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      pre_q   <= pre_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tgt_ready = (state_q == S_IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign duty0     = duty_q[0];
  assign duty1     = duty_q[1];
  assign duty2     = duty_q[2];
  assign duty3     = duty_q[3];

endmodule

// File: tb/tb_duty_fade_ctrl.sv
// Directed bench for duty_fade_ctrl with a short fade tick.
// Expected values are hand-computed for TICK_DIV=4.
module tb_duty_fade_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic [7:0] tgt0 = '0, tgt1 = '0, tgt2 = '0, tgt3 = '0;
  logic [7:0] step = 8'd1;
  logic       fade_en = 1'b0;
  logic [7:0] duty0, duty1, duty2, duty3;
  logic       busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  duty_fade_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt0(tgt0), .tgt1(tgt1), .tgt2(tgt2), .tgt3(tgt3),
    .step(step), .fade_en(fade_en),
    .duty0(duty0), .duty1(duty1), .duty2(duty2), .duty3(duty3),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tgt(input logic [7:0] a, b, c, d,
                         input logic [7:0] s, input logic f);
    tgt0 = a; tgt1 = b; tgt2 = c; tgt3 = d;
    step = s; fade_en = f;
  endtask

  task automatic accept();
    tgt_valid = 1'b1;
    cyc();
    tgt_valid = 1'b0;
  endtask

  task automatic chk_duty(input string tag, input logic [31:0] exp);
    chk(tag, {duty3, duty2, duty1, duty0}, exp);
  endtask

  task automatic jump_all(input logic [7:0] v);
    set_tgt(v, v, v, v, 8'd1, 1'b0);
    accept();
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
  endtask

  int n;

  initial begin
    #1;
    do_reset();
    chk_duty("rst_duty", 32'h0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_done", done, 0);

    // immediate jump
    set_tgt(8'h10, 8'h80, 8'hFF, 8'h00, 8'h01, 1'b0);
    accept();
    chk_duty("jmp_duty", 32'h00FF8010);
    chk("jmp_done", done, 1);
    chk("jmp_ready", tgt_ready, 0);
    cyc();
    chk("jmp_done_off", done, 0);
    chk("jmp_busy_off", busy, 0);

    // saturating ramp up
    do_reset();
    set_tgt(8'hFF, 8'h00, 8'h00, 8'h00, 8'h60, 1'b1);
    accept();
    chk("up_busy", busy, 1);
    for (int e = 1; e <= 13; e++) begin
      cyc();
      if (e == 3)  chk("up_e3", duty0, 8'h00);
      if (e == 4)  chk("up_e4", duty0, 8'h60);
      if (e == 8)  chk("up_e8", duty0, 8'hC0);
      if (e == 11) chk("up_e11_done", done, 0);
      if (e == 12) begin
        chk_duty("up_e12", 32'h000000FF);
        chk("up_e12_done", done, 1);
      end
      if (e == 13) chk("up_e13_done", done, 0);
    end

    // mixed direction
    jump_all(8'h80);
    set_tgt(8'hA0, 8'h50, 8'h80, 8'h80, 8'h20, 1'b1);
    accept();
    repeat (4) cyc();
    chk_duty("mix_t1", 32'h808060A0);
    chk("mix_t1_done", done, 0);
    repeat (4) cyc();
    chk_duty("mix_t2", 32'h808050A0);
    chk("mix_t2_done", done, 1);
    cyc();

    // step 0 behaves as step 1: 0x30 ticks for ch1
    jump_all(8'h80);
    set_tgt(8'hA0, 8'h50, 8'h80, 8'h80, 8'h00, 1'b1);
    accept();
    repeat (4) cyc();
    chk_duty("s0_t1", 32'h80807F81);
    n = 4;
    while (!done && n < 400) begin
      cyc();
      n++;
    end
    chk("s0_cycles", n, 192);
    chk_duty("s0_end", 32'h808050A0);
    cyc();

    // backpressure
    set_tgt(8'h20, 8'h50, 8'h80, 8'h80, 8'h40, 1'b1);
    accept();
    set_tgt(8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 1'b0);
    tgt_valid = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      if (e <= 8) begin
        chk($sformatf("bp_ready_%0d", e), tgt_ready, 0);
        chk($sformatf("bp_ch2_%0d", e), duty2, 8'h80);
      end
      if (e == 4) chk("bp_t1", duty0, 8'h60);
      if (e == 8) begin
        chk("bp_fin_done", done, 1);
        chk("bp_t2", duty0, 8'h20);
      end
      if (e == 9) begin
        chk("bp_idle_ready", tgt_ready, 1);
        chk_duty("bp_idle_duty", 32'h80805020);
      end
      if (e == 10) begin
        chk_duty("bp_acc_duty", 32'h44332211);
        chk("bp_acc_done", done, 1);
      end
    end
    tgt_valid = 1'b0;
    cyc();

    // reset mid-fade
    set_tgt(8'h91, 8'h22, 8'h33, 8'h44, 8'h10, 1'b1);
    accept();
    repeat (4) cyc();
    chk("rmf_t1", duty0, 8'h21);
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk_duty("rmf_duty", 32'h0);
    chk("rmf_busy", busy, 0);
    chk("rmf_done", done, 0);
    chk("rmf_ready", tgt_ready, 1);
    n = 0;
    for (int e = 0; e < 8; e++) begin
      cyc();
      if (done || busy) n++;
    end
    chk("rmf_quiet", n, 0);

    // no-op target with fading enabled
    set_tgt(8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 1'b1);
    accept();
    chk("noop_done", done, 1);
    chk_duty("noop_duty", 32'h0);
    cyc();
    chk("noop_busy", busy, 0);
    chk("noop_done_off", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
